// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the blocks that sit in front of the 4-bit ALU:
// the arbiter state encoding and the datapath widths.
// Ports: none (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W        = 4;
    localparam int OPND_W      = 4;
    localparam int RES_W       = 8;
    localparam int ALU_NUM_OPS = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker. A lone requester always wins.
// On a tie, the requester that was not served last wins.
// Ports:
//   valid[1:0]   in   request lines, bit N = requester N
//   last_served  in   index of the requester served most recently
//   grant[1:0]   out  one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. A single operation is in
// flight at a time: accept (IDLE) -> drive ALU (EXEC) -> return result (RESP).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b         request channel of requester N
//   rspN_valid/ready/data/err       response channel of requester N
//   alu_op/alu_a/alu_b              registered ALU inputs
//   alu_y                           combinational ALU result
//   busy                            high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_OPS    = ALU_NUM_OPS,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [RES_W-1:0]  rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [RES_W-1:0]  rsp1_data,
    output logic              rsp1_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_y,
    output logic              busy
);

    // One extra bit so NUM_OPS = 16 still compares correctly.
    localparam logic [OP_W:0] NUM_OPS_W = NUM_OPS[OP_W:0];

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_served_q, last_served_d;
    logic                err_q, err_d;
    logic [RES_W-1:0]    data_q, data_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [OPND_W-1:0]   alu_a_q, alu_a_d;
    logic [OPND_W-1:0]   alu_b_q, alu_b_d;

    logic [1:0]          grant;
    logic                can_accept;
    logic                accept;
    logic [OP_W-1:0]     sel_op;
    logic [OPND_W-1:0]   sel_a;
    logic [OPND_W-1:0]   sel_b;
    logic                sel_illegal;
    logic                owner_rsp_ready;

    rr_pick2 u_pick (
        .valid       ({req1_valid, req0_valid}),
        .last_served (last_served_q),
        .grant       (grant)
    );

    // Ready is forced low during reset so nothing is handshaken that the
    // reset is about to discard.
    assign can_accept = (state_q == IDLE) && !rst;
    assign accept     = can_accept && (grant != 2'b00);
    assign req0_ready = can_accept && grant[0];
    assign req1_ready = can_accept && grant[1];

    assign sel_op      = grant[1] ? req1_op : req0_op;
    assign sel_a       = grant[1] ? req1_a  : req0_a;
    assign sel_b       = grant[1] ? req1_b  : req0_b;
    assign sel_illegal = ({1'b0, sel_op} >= NUM_OPS_W);

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state logic. Illegal opcodes never touch the ALU inputs, so the
    // previous legal operation stays on the ALU and the result is forced to 0.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        err_d         = err_q;
        data_d        = data_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant[1];
                    err_d   = sel_illegal;
                    if (!sel_illegal) begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = err_q ? '0 : alu_y;
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    last_served_d = owner_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state, including the registered ALU inputs and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_served_q <= ~FIRST_PRIO;
            err_q         <= 1'b0;
            data_q        <= '0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            err_q         <= err_d;
            data_q        <= data_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
        end
    end

    // The payload is only shown to the owner while its response is valid.
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp0_data  = rsp0_valid ? data_q : '0;
    assign rsp1_data  = rsp1_valid ? data_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign busy   = (state_q != IDLE);

endmodule
